// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
// Build option MOLE_ADAPTIVE_SPEED_EN (used by mole_scheduler) shrinks the up-time after each hit.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      UP,
      BLANK,
      GAP,
      DONE
   } state_t;

   localparam logic [3:0]  MOLE_BLANK     = 4'hF;
   localparam int          MOLE_POSITIONS = 10;
   localparam logic [15:0] LFSR_MASK      = 16'hB400;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR, advances every cycle; value is the register itself (0 latency).
// No backpressure: there is no enable, the sequence never stalls.
module mole_lfsr
   import mole_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Right-shifting Galois form: the bit shifted out folds back through the tap mask.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: start->mole_valid 2 cycles, key->hit 1 cycle, all outputs registered.
// No backpressure (display and keypad are strobes); MOLE_ADAPTIVE_SPEED_EN enables shrinking up-time.
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int          UP_CYCLES  = 50_000_000,
   parameter int          GAP_CYCLES = 12_500_000,
   parameter int          ROUNDS     = 20,
   parameter int          TIMER_W    = 27,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] key_num,
   input  logic       key_valid,
   output logic [3:0] mole_num,
   output logic       mole_valid,
   output logic       hit,
   output logic       miss,
   output logic [7:0] score,
   output logic [7:0] round,
   output logic       busy,
   output logic       done
);

   localparam logic [TIMER_W-1:0] UP_LOAD  = TIMER_W'(UP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [3:0]         prev_q, prev_d;
   logic [3:0]         mole_num_q, mole_num_d;
   logic               mole_valid_q, mole_valid_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic [7:0]         score_q, score_d;
   logic [7:0]         round_q, round_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [15:0]        lfsr_val;
   logic               unused_lfsr;
   logic [3:0]         cand;
   logic [TIMER_W-1:0] spawn_load;

   mole_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .lfsr  (lfsr_val)
   );

   assign unused_lfsr = ^lfsr_val[15:4];

   // Fold 10..15 onto 4..9, then step past the previous mole so it never repeats.
   always_comb begin
      cand = lfsr_val[3:0];
      if (cand >= 4'(MOLE_POSITIONS)) begin
         cand = cand - 4'd6;
      end
      if (cand == prev_q) begin
         cand = (cand == 4'(MOLE_POSITIONS - 1)) ? 4'd0 : cand + 4'd1;
      end
   end

`ifdef MOLE_ADAPTIVE_SPEED_EN
   localparam logic [TIMER_W-1:0] UP_FULL  = TIMER_W'(UP_CYCLES);
   localparam logic [TIMER_W-1:0] UP_FLOOR = TIMER_W'(UP_CYCLES / 4);

   logic [TIMER_W-1:0] up_len_q, up_len_d;
   logic [TIMER_W-1:0] up_shrunk;

   always_comb begin
      up_shrunk  = up_len_q - (up_len_q >> 3);
      spawn_load = up_len_q - T_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_len_q <= UP_FULL;
      end else begin
         up_len_q <= up_len_d;
      end
   end
`else
   always_comb begin
      spawn_load = UP_LOAD;
   end
`endif

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      prev_d       = prev_q;
      mole_num_d   = mole_num_q;
      mole_valid_d = 1'b0;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      score_d      = score_q;
      round_d      = round_q;
`ifdef MOLE_ADAPTIVE_SPEED_EN
      up_len_d     = up_len_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SPAWN;
               score_d = 8'd0;
               round_d = 8'd0;
`ifdef MOLE_ADAPTIVE_SPEED_EN
               up_len_d = UP_FULL;
`endif
            end
         end
         SPAWN: begin
            mole_num_d   = cand;
            prev_d       = cand;
            mole_valid_d = 1'b1;
            timer_d      = spawn_load;
            state_d      = UP;
         end
         UP: begin
            // A correct key wins over a timeout landing in the same cycle.
            if (key_valid && (key_num == mole_num_q)) begin
               hit_d   = 1'b1;
               state_d = BLANK;
               if (score_q != 8'hFF) begin
                  score_d = score_q + 8'd1;
               end
`ifdef MOLE_ADAPTIVE_SPEED_EN
               up_len_d = (up_shrunk < UP_FLOOR) ? UP_FLOOR : up_shrunk;
`endif
            end else if (timer_q == '0) begin
               miss_d  = 1'b1;
               state_d = BLANK;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         BLANK: begin
            mole_num_d   = MOLE_BLANK;
            mole_valid_d = 1'b1;
            timer_d      = GAP_LOAD;
            state_d      = GAP;
         end
         GAP: begin
            if (timer_q == '0) begin
               round_d = round_q + 8'd1;
               state_d = ((round_q + 8'd1) == 8'(ROUNDS)) ? DONE : SPAWN;
            end else begin
               timer_d = timer_q - T_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE) && (state_d != DONE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         prev_q       <= MOLE_BLANK;
         mole_num_q   <= MOLE_BLANK;
         mole_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         score_q      <= 8'd0;
         round_q      <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         prev_q       <= prev_d;
         mole_num_q   <= mole_num_d;
         mole_valid_q <= mole_valid_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         score_q      <= score_d;
         round_q      <= round_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign mole_num   = mole_num_q;
   assign mole_valid = mole_valid_q;
   assign hit        = hit_q;
   assign miss       = miss_q;
   assign score      = score_q;
   assign round      = round_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with UP_CYCLES=8, GAP_CYCLES=4, ROUNDS=3.
module tb_mole_scheduler;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] key_num;
   logic       key_valid;
   logic [3:0] mole_num;
   logic       mole_valid;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic [7:0] round;
   logic       busy;
   logic       done;

   int         n_cmp;
   int         n_err;
   int         mv_viol;
   logic       mv_last;
   logic       mv_seen;
   logic [15:0] m_lfsr;
   logic [3:0]  prev_m;
   logic [3:0]  exp_m;
   logic [3:0]  wrong_k;

   mole_scheduler #(
      .UP_CYCLES  (8),
      .GAP_CYCLES (4),
      .ROUNDS     (3),
      .TIMER_W    (4),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_num    (key_num),
      .key_valid  (key_valid),
      .mole_num   (mole_num),
      .mole_valid (mole_valid),
      .hit        (hit),
      .miss       (miss),
      .score      (score),
      .round      (round),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference of the 0xB400 Galois LFSR.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 16'hACE1;
      end else begin
         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   initial begin
      mv_viol = 0;
      mv_last = 1'b0;
   end

   always @(negedge clk) begin
      if (mv_last && mole_valid) mv_viol = mv_viol + 1;
      mv_last = mole_valid;
   end

   function automatic logic [3:0] map_pos(input logic [3:0] raw, input logic [3:0] prev);
      logic [3:0] c;
      c = raw;
      if (c >= 4'd10) c = c - 4'd6;
      if (c == prev) c = (c == 4'd9) ? 4'd0 : c + 4'd1;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called while the DUT sits in SPAWN; returns one cycle later in the first UP cycle.
   task automatic do_spawn(input string tag);
      exp_m = map_pos(m_lfsr[3:0], prev_m);
      tick();
      chk({tag, "_mv"}, mole_valid, 1);
      chk({tag, "_num"}, mole_num, exp_m);
      chk({tag, "_range"}, mole_num < 4'd10, 1);
      chk({tag, "_ne_prev"}, mole_num != prev_m, 1);
      prev_m = exp_m;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_num"}, mole_num, 4'hF);
      chk({tag, "_mv"}, mole_valid, 0);
      chk({tag, "_hit"}, hit, 0);
      chk({tag, "_miss"}, miss, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_round"}, round, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_lfsr"}, dut.lfsr_val, 16'hACE1);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      key_num   = 4'd0;
      key_valid = 1'b0;
      prev_m    = 4'hF;
      mv_seen   = 1'b0;

      repeat (3) tick();
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // Idle: LFSR free-runs, display untouched.
      for (int i = 0; i < 20; i++) begin
         tick();
         mv_seen = mv_seen | mole_valid;
         if (i == 0) chk("lfsr_step1", dut.lfsr_val, 16'hE270);
         chk("lfsr_model", dut.lfsr_val, m_lfsr);
      end
      chk("idle_num", mole_num, 4'hF);
      chk("idle_mv_seen", mv_seen, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);

      // Round 0: no key -> miss.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("spawn_busy", busy, 1);
      do_spawn("r0");
      repeat (7) tick();
      chk("r0_nomiss_early", miss, 0);
      tick();
      chk("r0_miss", miss, 1);
      chk("r0_hit", hit, 0);
      chk("r0_score", score, 0);
      tick();
      chk("r0_blank_mv", mole_valid, 1);
      chk("r0_blank_num", mole_num, 4'hF);
      chk("r0_miss_pulse", miss, 0);
      repeat (3) tick();
      chk("r0_gap_round", round, 0);
      tick();
      chk("r1_round", round, 1);

      // Round 1: wrong key, then correct key 3 cycles into UP; keys in GAP ignored.
      do_spawn("r1");
      wrong_k   = (exp_m == 4'd9) ? 4'd0 : exp_m + 4'd1;
      key_num   = wrong_k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("r1_wrong_hit", hit, 0);
      chk("r1_wrong_miss", miss, 0);
      chk("r1_wrong_score", score, 0);
      tick();
      key_num   = exp_m;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("r1_hit", hit, 1);
      chk("r1_score", score, 1);
      chk("r1_hit_mv", mole_valid, 0);
      tick();
      chk("r1_blank_mv", mole_valid, 1);
      chk("r1_blank_num", mole_num, 4'hF);
      chk("r1_hit_pulse", hit, 0);
      key_num   = exp_m;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("r1_gap_key_score", score, 1);
      chk("r1_gap_key_hit", hit, 0);
      repeat (2) tick();
      chk("r1_gap_round", round, 1);
      tick();
      chk("r2_round", round, 2);

      // Round 2: start during UP ignored; correct key on the final UP cycle.
      do_spawn("r2");
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("r2_start_busy", busy, 1);
      chk("r2_start_score", score, 1);
      chk("r2_start_round", round, 2);
      repeat (6) tick();
      key_num   = exp_m;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      chk("r2_last_hit", hit, 1);
      chk("r2_last_miss", miss, 0);
      chk("r2_last_score", score, 2);
      tick();
      chk("r2_blank_mv", mole_valid, 1);
      chk("r2_nomiss_late", miss, 0);
      repeat (3) tick();
      chk("r2_gap_busy", busy, 1);
      tick();
      chk("done_done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_round", round, 3);
      chk("done_score", score, 2);
      repeat (3) tick();
      chk("hold_done", done, 1);
      chk("hold_score", score, 2);
      chk("hold_num", mole_num, 4'hF);

      // Restart from DONE.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("g2_score", score, 0);
      chk("g2_round", round, 0);
      chk("g2_done", done, 0);
      chk("g2_busy", busy, 1);
      do_spawn("g2");

      // Asynchronous reset mid-UP.
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      prev_m = 4'hF;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      do_spawn("post_rst");

      chk("mv_consecutive", mv_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Game sequencer for the whack-a-mole datapath. Picks a pseudo-random mole position 0-9 and drives it to the LED display through its num/num_valid interface.
- Runs a per-mole up-time window and checks keypad presses against the lit mole. Counts hits and misses, then blanks the display between moles.
- Runs a fixed number of rounds per game, then holds in a done state until restarted.

Parameters:
- UP_CYCLES, 50_000_000: clock cycles a mole stays lit (1 s at 50 MHz).
- GAP_CYCLES, 12_500_000: blank cycles between moles.
- ROUNDS, 20: moles per game; legal range 1..255.
- TIMER_W, 27: timer width; must hold max(UP_CYCLES, GAP_CYCLES).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset.
- start, in, 1: single-cycle pulse that begins a game.
- key_num, in, 4: decoded keypad digit.
- key_valid, in, 1: single-cycle strobe qualifying key_num.
- mole_num, out, 4: position to display; 4'hF means blank.
- mole_valid, out, 1: single-cycle update strobe to the LED display.
- hit, out, 1: pulse on a correct press.
- miss, out, 1: pulse when a mole times out.
- score, out, 8: hits this game, saturating at 255.
- round, out, 8: moles completed this game.
- busy, out, 1: high while a game runs.
- done, out, 1: high in DONE.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports are named clk and rst_n.

Behaviour:
- Reset values: mole_num=4'hF, mole_valid=0, hit=0, miss=0, score=0, round=0, busy=0, done=0, state=IDLE, LFSR=LFSR_SEED.
- Reset mid-game aborts immediately to these values.
- All outputs are registered.
- LFSR: 16-bit Galois, taps 16,14,13,11 (mask 16'hB400). Advances every cycle regardless of state.
- Candidate position from c = lfsr[3:0]:
  - if c >= 10, c = c - 6;
  - if c equals the previous mole, c = (c==9) ? 0 : c+1.
  - The previous mole resets to 4'hF.
- IDLE:
  - busy=0.
  - start -> SPAWN, clearing score and round.
- SPAWN (1 cycle):
  - Register mole_num=c and pulse mole_valid=1 the following cycle.
  - Load timer=UP_CYCLES-1 and go to UP.
  - busy=1 from SPAWN onward.
- UP: lasts exactly UP_CYCLES cycles; the timer decrements each cycle.
  - key_valid with key_num==mole_num: next cycle hit=1 and score++ (saturating); go to BLANK.
  - key_valid with a wrong digit: ignored.
  - Timer reaches 0 with no hit: miss=1 next cycle; go to BLANK.
  - A correct key in the same cycle the timer reaches 0 counts as a hit, not a miss.
- BLANK (1 cycle):
  - mole_num=4'hF, mole_valid pulse (the display clears).
  - Load timer=GAP_CYCLES-1 and go to GAP.
- GAP:
  - Keys are ignored.
  - When the timer reaches 0, round++.
  - If round+1 == ROUNDS go to DONE, else go to SPAWN.
- DONE:
  - done=1, busy=0; score and round hold.
  - start -> SPAWN with score and round cleared, done=0.
- start is ignored outside IDLE and DONE.
- Latency from start to mole_valid: 2 cycles (start at T, SPAWN at T+1, mole_valid at T+2).
- Latency from correct key to the hit pulse: 1 cycle. The blank mole_valid follows 1 cycle after hit.
- mole_valid never pulses on two consecutive cycles.

Optional Feature:
- Macro: MOLE_ADAPTIVE_SPEED_EN.
- Defined:
  - A per-game up_len register starts at UP_CYCLES.
  - Each hit sets up_len = up_len - (up_len>>3), floored at UP_CYCLES/4.
  - SPAWN loads timer=up_len-1.
  - up_len resets to UP_CYCLES on start and on reset.
- Undefined: up-time is fixed at UP_CYCLES and no up_len register exists.

Decomposition:
- Package mole_pkg holds:
  - the state enum (IDLE, SPAWN, UP, BLANK, GAP, DONE);
  - MOLE_BLANK = 4'hF;
  - MOLE_POSITIONS = 10;
  - LFSR_MASK = 16'hB400.
- One sub-module: mole_lfsr. It contains the 16-bit LFSR with a seed parameter and outputs the current value.
- Position mapping and repeat avoidance stay in mole_scheduler.

Test Plan (UP_CYCLES=8, GAP_CYCLES=4, ROUNDS=3, MOLE_ADAPTIVE_SPEED_EN undefined unless noted):
- Reset then idle 20 cycles -> mole_num=F, mole_valid never asserted, busy=0, done=0, LFSR sequence matches the reference model.
- start at T -> mole_valid at T+2 with mole_num in 0..9 and different from the previous mole. No key -> miss pulse exactly 8 cycles after SPAWN, blank mole_valid next cycle, score=0.
- Correct key 3 cycles into UP -> hit the next cycle, score=1, blank strobe 1 cycle after hit, and the next SPAWN after 4 GAP cycles. Wrong key before it -> no effect.
- Correct key on the final UP cycle -> hit=1, miss=0, score increments.
- Play 3 rounds (hit, miss, hit) -> done=1, busy=0, score=2, round=3. A second start -> score=0, round=0, new game.
- Assert rst_n=0 mid-UP -> all outputs at reset values in the same cycle. start during UP -> ignored.
- With MOLE_ADAPTIVE_SPEED_EN and UP_CYCLES=64: successive hits give windows 64, 56, 49, 43 cycles, floored at 16.
